// File: rtl/sdram_cmd_arbiter.sv
// sdram_cmd_arbiter: grants the SDRAM controller to one of three clients
// (video fetch, cache write-back, cache fill), issues a single command per
// grant, holds it until acknowledged and then steers the data beats.
// Video reads of 16-bit words are paired into 32-bit queue writes.
// Optional feature macro: VSYNC_RESYNC_EN (a vsync rising edge restarts the
// video fetch address at 0 on the next video grant).
module sdram_cmd_arbiter #(
    parameter int VID_LAST    = 19199,
    parameter int VID_WORDS   = 16,
    parameter int CACHE_WORDS = 128
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        vid_en,
    input  logic        vid_low,
    input  logic        vsync,
    input  logic        wb_req,
    input  logic [16:0] wb_addr,
    input  logic        fill_req,
    input  logic [16:0] fill_addr,
    output logic [1:0]  sys_cmd,
    output logic [22:0] sys_addr,
    input  logic [1:0]  sys_cmd_ack,
    input  logic        sys_rd_data_valid,
    input  logic        sys_wr_data_valid,
    input  logic [15:0] sys_dout,
    output logic [31:0] vq_data,
    output logic        vq_we,
    output logic        cache_fill_en,
    output logic        cache_wb_en,
    output logic [1:0]  grant,
    output logic        busy
);

    localparam int MAX_WORDS = (VID_WORDS > CACHE_WORDS) ? VID_WORDS : CACHE_WORDS;
    localparam int CW        = $clog2(MAX_WORDS + 1);

    localparam logic [CW-1:0] VID_LIM    = CW'(VID_WORDS);
    localparam logic [CW-1:0] CACHE_LIM  = CW'(CACHE_WORDS);
    localparam logic [CW-1:0] CNT_ONE    = CW'(1);
    localparam logic [CW-1:0] CNT_ZERO   = CW'(0);
    localparam logic [18:0]   VID_LAST_A = 19'(VID_LAST);

    localparam logic [1:0] G_NONE  = 2'b00;
    localparam logic [1:0] G_WB    = 2'b01;
    localparam logic [1:0] G_VID   = 2'b10;
    localparam logic [1:0] G_FILL  = 2'b11;

    localparam logic [1:0] C_NOP   = 2'b00;
    localparam logic [1:0] C_WR256 = 2'b01;
    localparam logic [1:0] C_RD32  = 2'b10;
    localparam logic [1:0] C_RD256 = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_CMD  = 2'b01,
        S_XFER = 2'b10
    } state_t;

    state_t         r_state;
    logic [1:0]     r_grant;
    logic [1:0]     r_sys_cmd;
    logic [22:0]    r_sys_addr;
    logic           r_busy;
    logic           r_vq_we;
    logic [31:0]    r_vq_data;
    logic [15:0]    r_hold;
    logic           r_pair;
    logic [18:0]    r_vidadr;
    logic [CW-1:0]  r_beat_cnt;
    logic           r_rst_done;

    logic           w_vid_req;
    logic           w_vid_grant;
    logic           w_beat;
    logic           w_last;
    logic [CW-1:0]  w_limit;
    logic [18:0]    w_vid_base;

    assign w_vid_req   = vid_en & vid_low;
    // The first cycle after reset release only arms r_rst_done, so no grant
    // can happen before the second rising edge.
    assign w_vid_grant = (r_state == S_IDLE) & r_rst_done & w_vid_req;

`ifdef VSYNC_RESYNC_EN
    logic r_vsync_d;
    logic r_vs_pend;

    // Remember a vsync rising edge until the next video grant consumes it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_vsync_d <= 1'b0;
            r_vs_pend <= 1'b0;
        end else begin
            r_vsync_d <= vsync;
            if (vsync && !r_vsync_d) begin
                r_vs_pend <= 1'b1;
            end else if (w_vid_grant) begin
                r_vs_pend <= 1'b0;
            end else begin
                r_vs_pend <= r_vs_pend;
            end
        end
    end

    // A pending resync restarts the frame at address 0.
    always_comb begin
        w_vid_base = r_vidadr;
        if (r_vs_pend) begin
            w_vid_base = 19'd0;
        end else begin
            w_vid_base = r_vidadr;
        end
    end
`else
    logic w_unused_vsync;
    assign w_unused_vsync = vsync;

    // Without resync the video address only advances by acknowledged commands.
    always_comb begin
        w_vid_base = r_vidadr;
    end
`endif

    // Select the beat strobe and burst length belonging to the current owner.
    always_comb begin
        w_beat  = 1'b0;
        w_limit = CACHE_LIM;
        case (r_grant)
            G_WB: begin
                w_beat  = sys_wr_data_valid;
                w_limit = CACHE_LIM;
            end
            G_VID: begin
                w_beat  = sys_rd_data_valid;
                w_limit = VID_LIM;
            end
            G_FILL: begin
                w_beat  = sys_rd_data_valid;
                w_limit = CACHE_LIM;
            end
            default: begin
                w_beat  = 1'b0;
                w_limit = CACHE_LIM;
            end
        endcase
        if (r_state != S_XFER) begin
            w_beat = 1'b0;
        end else begin
            w_beat = w_beat;
        end
    end

    assign w_last = ((r_beat_cnt + CNT_ONE) == w_limit);

    // Arbitration, command issue/hold, beat counting and video word pairing.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= S_IDLE;
            r_grant    <= G_NONE;
            r_sys_cmd  <= C_NOP;
            r_sys_addr <= 23'd0;
            r_busy     <= 1'b0;
            r_vq_we    <= 1'b0;
            r_vq_data  <= 32'd0;
            r_hold     <= 16'd0;
            r_pair     <= 1'b0;
            r_vidadr   <= 19'd0;
            r_beat_cnt <= CNT_ZERO;
            r_rst_done <= 1'b0;
        end else begin
            r_rst_done <= 1'b1;
            r_vq_we    <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_beat_cnt <= CNT_ZERO;
                    r_pair     <= 1'b0;
                    if (w_vid_grant) begin
                        r_grant    <= G_VID;
                        r_sys_cmd  <= C_RD32;
                        r_sys_addr <= {1'b1, w_vid_base, 3'b000};
                        r_vidadr   <= w_vid_base;
                        r_busy     <= 1'b1;
                        r_state    <= S_CMD;
                    end else if (r_rst_done && wb_req) begin
                        r_grant    <= G_WB;
                        r_sys_cmd  <= C_WR256;
                        r_sys_addr <= {wb_addr, 6'b000000};
                        r_busy     <= 1'b1;
                        r_state    <= S_CMD;
                    end else if (r_rst_done && fill_req) begin
                        r_grant    <= G_FILL;
                        r_sys_cmd  <= C_RD256;
                        r_sys_addr <= {fill_addr, 6'b000000};
                        r_busy     <= 1'b1;
                        r_state    <= S_CMD;
                    end else begin
                        r_state    <= S_IDLE;
                    end
                end
                S_CMD: begin
                    if (sys_cmd_ack != 2'b00) begin
                        r_sys_cmd <= C_NOP;
                        r_state   <= S_XFER;
                        if (r_grant == G_VID) begin
                            r_vidadr <= (r_vidadr == VID_LAST_A) ? 19'd0 : (r_vidadr + 19'd1);
                        end else begin
                            r_vidadr <= r_vidadr;
                        end
                    end else begin
                        r_state <= S_CMD;
                    end
                end
                S_XFER: begin
                    if (w_beat) begin
                        if (r_grant == G_VID) begin
                            if (r_pair) begin
                                r_vq_we   <= 1'b1;
                                r_vq_data <= {sys_dout, r_hold};
                                r_pair    <= 1'b0;
                            end else begin
                                r_hold <= sys_dout;
                                r_pair <= 1'b1;
                            end
                        end else begin
                            r_pair <= r_pair;
                        end
                        if (w_last) begin
                            r_state    <= S_IDLE;
                            r_grant    <= G_NONE;
                            r_busy     <= 1'b0;
                            r_beat_cnt <= CNT_ZERO;
                        end else begin
                            r_beat_cnt <= r_beat_cnt + CNT_ONE;
                        end
                    end else begin
                        r_state <= S_XFER;
                    end
                end
                default: begin
                    r_state   <= S_IDLE;
                    r_grant   <= G_NONE;
                    r_sys_cmd <= C_NOP;
                    r_busy    <= 1'b0;
                end
            endcase
        end
    end

    assign sys_cmd       = r_sys_cmd;
    assign sys_addr      = r_sys_addr;
    assign grant         = r_grant;
    assign busy          = r_busy;
    assign vq_we         = r_vq_we;
    assign vq_data       = r_vq_data;
    // Cache strobes must line up with the controller data word, so they
    // follow the valid strobes directly while the matching burst is open.
    assign cache_fill_en = (r_state == S_XFER) & (r_grant == G_FILL) & sys_rd_data_valid;
    assign cache_wb_en   = (r_state == S_XFER) & (r_grant == G_WB) & sys_wr_data_valid;

endmodule

// File: tb/tb_sdram_cmd_arbiter.sv
// Scoreboard bench for sdram_cmd_arbiter: stimulus pushes expected commands
// and video words into queues; a negedge monitor pops and compares them.
module tb_sdram_cmd_arbiter;

    localparam int VL = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        vid_en, vid_low, vsync, wb_req, fill_req;
    logic [16:0] wb_addr, fill_addr;
    logic [1:0]  sys_cmd, sys_cmd_ack, grant;
    logic [22:0] sys_addr;
    logic        sys_rd_data_valid, sys_wr_data_valid;
    logic [15:0] sys_dout;
    logic [31:0] vq_data;
    logic        vq_we, cache_fill_en, cache_wb_en, busy;

    int checks = 0;
    int errors = 0;
    int vq_cnt = 0;
    int fill_cnt = 0;
    int wb_cnt = 0;
    logic [18:0] exp_vid;

    logic [26:0] cmd_q[$];
    logic [31:0] vq_q[$];

    sdram_cmd_arbiter #(.VID_LAST(VL)) dut (
        .clk(clk), .rst(rst), .vid_en(vid_en), .vid_low(vid_low), .vsync(vsync),
        .wb_req(wb_req), .wb_addr(wb_addr), .fill_req(fill_req), .fill_addr(fill_addr),
        .sys_cmd(sys_cmd), .sys_addr(sys_addr), .sys_cmd_ack(sys_cmd_ack),
        .sys_rd_data_valid(sys_rd_data_valid), .sys_wr_data_valid(sys_wr_data_valid),
        .sys_dout(sys_dout), .vq_data(vq_data), .vq_we(vq_we),
        .cache_fill_en(cache_fill_en), .cache_wb_en(cache_wb_en),
        .grant(grant), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] vbeat(input int k);
        logic [3:0] d;
        d = 4'(k + 1);
        return {d, d, d, d};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_zero(input string name);
        chk(name, {sys_cmd, sys_addr, grant, busy, vq_we, vq_data, cache_fill_en, cache_wb_en}, 64'd0);
    endtask

    task automatic wait_cmd();
        int n;
        n = 0;
        while (sys_cmd == 2'b00 && n < 100) begin
            tick();
            n++;
        end
        chk("cmd_seen", 64'(sys_cmd != 2'b00), 64'd1);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy !== 1'b0 && n < 400) begin
            tick();
            n++;
        end
        chk("idle_seen", 64'(busy), 64'd0);
    endtask

    task automatic ack(input int d);
        repeat (d) tick();
        sys_cmd_ack = 2'b01;
        tick();
        sys_cmd_ack = 2'b00;
        chk("nop_after_ack", 64'(sys_cmd), 64'd0);
    endtask

    task automatic push_vid();
        cmd_q.push_back({2'b10, 1'b1, exp_vid, 3'b000, 2'b10});
    endtask

    task automatic adv_vid();
        exp_vid = (exp_vid == 19'(VL)) ? 19'd0 : exp_vid + 19'd1;
    endtask

    task automatic vid_beats(input int n);
        for (int p = 0; p < n / 2; p++) vq_q.push_back({vbeat(2 * p + 1), vbeat(2 * p)});
        for (int k = 0; k < n; k++) begin
            sys_rd_data_valid = 1'b1;
            sys_dout = vbeat(k);
            tick();
        end
        sys_rd_data_valid = 1'b0;
    endtask

    task automatic video_txn(input int d);
        push_vid();
        vid_low = 1'b1;
        wait_cmd();
        vid_low = 1'b0;
        ack(d);
        adv_vid();
        vid_beats(16);
        wait_idle();
    endtask

    // Monitor: compares issued commands, command hold and video words.
    initial begin
        logic [1:0]  prev_cmd;
        logic [22:0] prev_addr;
        logic [26:0] e27;
        logic [31:0] e32;
        prev_cmd = 2'b00;
        prev_addr = 23'd0;
        forever begin
            @(negedge clk);
            if (sys_cmd != 2'b00) begin
                if (prev_cmd == 2'b00) begin
                    if (cmd_q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL cmd_issue: got %0h expected none", {sys_cmd, sys_addr, grant});
                    end else begin
                        e27 = cmd_q.pop_front();
                        chk("cmd_issue", 64'({sys_cmd, sys_addr, grant}), 64'(e27));
                    end
                end else begin
                    chk("cmd_hold", 64'({sys_cmd, sys_addr}), 64'({prev_cmd, prev_addr}));
                end
            end
            if (vq_we === 1'b1) begin
                vq_cnt++;
                if (vq_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL vq_word: got %0h expected none", vq_data);
                end else begin
                    e32 = vq_q.pop_front();
                    chk("vq_word", 64'(vq_data), 64'(e32));
                end
            end
            if (cache_fill_en === 1'b1) fill_cnt++;
            if (cache_wb_en === 1'b1) wb_cnt++;
            prev_cmd = sys_cmd;
            prev_addr = sys_addr;
        end
    end

    // Stimulus: directed vectors with hand-computed expectations.
    initial begin
        rst = 1'b0;
        vid_en = 1'b1; vid_low = 1'b1; vsync = 1'b0;
        wb_req = 1'b1; wb_addr = 17'h1ABCD;
        fill_req = 1'b1; fill_addr = 17'h00123;
        sys_cmd_ack = 2'b00; sys_rd_data_valid = 1'b0; sys_wr_data_valid = 1'b0;
        sys_dout = 16'h0000;
        exp_vid = 19'd0;
        repeat (3) tick();
        chk_zero("reset_state");

        // All three requesters at once: video, then write-back, then fill.
        push_vid();
        cmd_q.push_back({2'b01, 17'h1ABCD, 6'b000000, 2'b01});
        cmd_q.push_back({2'b11, 17'h00123, 6'b000000, 2'b11});
        rst = 1'b1;
        tick();
        chk("first_edge_no_grant", 64'(grant), 64'd0);
        wait_cmd();
        vid_low = 1'b0;
        ack(0);
        adv_vid();
        vq_cnt = 0;
        vid_beats(16);
        wait_idle();
        sys_rd_data_valid = 1'b1;
        tick();
        sys_rd_data_valid = 1'b0;
        chk("vq_pulses", 64'(vq_cnt), 64'd8);

        // Write-back with a 7-cycle acknowledge delay; stray read strobes.
        wait_cmd();
        chk("wb_grant", 64'(grant), 64'h1);
        wb_req = 1'b0;
        fill_cnt = 0;
        wb_cnt = 0;
        ack(7);
        for (int k = 0; k < 128; k++) begin
            sys_wr_data_valid = 1'b1;
            sys_rd_data_valid = (k < 4);
            tick();
        end
        sys_wr_data_valid = 1'b0;
        sys_rd_data_valid = 1'b0;
        wait_idle();
        chk("wb_beats", 64'(wb_cnt), 64'd128);
        chk("no_fill_in_wb", 64'(fill_cnt), 64'd0);

        // Fill interrupted by reset after 5 beats.
        wait_cmd();
        fill_req = 1'b0;
        fill_cnt = 0;
        ack(2);
        for (int k = 0; k < 5; k++) begin
            sys_rd_data_valid = 1'b1;
            tick();
        end
        chk("fill_partial", 64'(fill_cnt), 64'd5);
        rst = 1'b0;
        #1;
        chk_zero("reset_mid_fill");
        tick();
        sys_rd_data_valid = 1'b0;
        rst = 1'b1;
        exp_vid = 19'd0;

        // Fresh fill: exactly 128 strobes despite 3 extra valid beats.
        fill_addr = 17'h0F0F0;
        cmd_q.push_back({2'b11, 17'h0F0F0, 6'b000000, 2'b11});
        fill_req = 1'b1;
        wait_cmd();
        fill_req = 1'b0;
        fill_cnt = 0;
        ack(1);
        for (int k = 0; k < 131; k++) begin
            sys_rd_data_valid = 1'b1;
            tick();
        end
        sys_rd_data_valid = 1'b0;
        chk("fill_beats", 64'(fill_cnt), 64'd128);
        chk("fill_done_idle", 64'(busy), 64'd0);

        // Video interrupted mid-pair; the held half-word must be discarded.
        push_vid();
        vid_low = 1'b1;
        wait_cmd();
        vid_low = 1'b0;
        ack(0);
        vid_beats(3);
        rst = 1'b0;
        #1;
        chk_zero("reset_mid_video");
        tick();
        rst = 1'b1;
        exp_vid = 19'd0;
        video_txn(0);

        // Address wrap from VL to 0; ack held high during one burst.
        for (int t = 0; t < 6; t++) begin
            push_vid();
            vid_low = 1'b1;
            wait_cmd();
            vid_low = 1'b0;
            ack(1);
            adv_vid();
            sys_cmd_ack = (t == 2) ? 2'b11 : 2'b00;
            vid_beats(16);
            sys_cmd_ack = 2'b00;
            wait_idle();
        end

        // vsync pulse: restarts at 0 only when the resync feature is built in.
        vsync = 1'b1;
        tick();
        vsync = 1'b0;
        tick();
`ifdef VSYNC_RESYNC_EN
        exp_vid = 19'd0;
`endif
        video_txn(0);
        video_txn(0);

        repeat (3) tick();
        chk("cmd_q_drained", 64'(cmd_q.size()), 64'd0);
        chk("vq_q_drained", 64'(vq_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
